// File: rtl/outer_prod_pkg.sv
// outer_prod_pkg: shared FSM state type, in_mode bit positions and default sizes for outer_prod_gen.
package outer_prod_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_OUT  = 2'd2
   } state_e;

   localparam int MODE_ELEM = 0;
   localparam int MODE_COL  = 1;

   localparam int DEF_N = 16;
   localparam int DEF_W = 4;

endpackage

// File: rtl/outer_prod_gen_op_mul.sv
// op_mul: combinational unsigned W x W -> 2W multiplier, exact.
module op_mul #(
   parameter int W = 4
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);

   assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/outer_prod_gen.sv
// outer_prod_gen: loads two N-element vectors, then streams their outer or element-wise products.
// Define OUTER_PROD_COLMAJOR_EN to let in_mode bit1 select column-major order in outer mode.
module outer_prod_gen
   import outer_prod_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   input  logic [1:0]     in_mode,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic           out_ready,
   output logic           out_valid,
   output logic [2*W-1:0] out_data
);

   localparam int LG = $clog2(N);

   state_e            state_q, state_d;
   logic [LG-1:0]     ld_cnt_q, ld_cnt_d;
   logic [2*LG-1:0]   beat_q, beat_d;
   logic              elem_q, elem_d;
   logic              col;
   logic              wr_en;
   logic              last;
   logic [LG-1:0]     hi, lo, a_idx, b_idx;
   logic [2*W-1:0]    prod;
   logic [W-1:0]      a_q [N];
   logic [W-1:0]      b_q [N];

`ifdef OUTER_PROD_COLMAJOR_EN
   logic col_q, col_d;
   assign col = col_q;
`else
   logic unused_mode_col;
   assign unused_mode_col = in_mode[MODE_COL];
   assign col = 1'b0;
`endif

   // Beat counter splits into outer (hi) and inner (lo) indices; inner wrap carries into outer.
   assign hi    = beat_q[2*LG-1:LG];
   assign lo    = beat_q[LG-1:0];
   assign a_idx = (elem_q || col) ? lo : hi;
   assign b_idx = (elem_q || !col) ? lo : hi;
   assign last  = elem_q ? (lo == LG'(N - 1)) : (&beat_q);

   op_mul #(.W(W)) u_mul (
      .a_i (a_q[a_idx]),
      .b_i (b_q[b_idx]),
      .p_o (prod)
   );

   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_valid ? prod : '0;

   // Next-state logic: load sequencing, abort on in_valid gap, beat advance on handshake.
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      beat_d   = beat_q;
      elem_d   = elem_q;
      wr_en    = 1'b0;
`ifdef OUTER_PROD_COLMAJOR_EN
      col_d    = col_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               wr_en    = 1'b1;
               elem_d   = in_mode[MODE_ELEM];
`ifdef OUTER_PROD_COLMAJOR_EN
               col_d    = in_mode[MODE_COL];
`endif
               ld_cnt_d = LG'(1);
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (ld_cnt_q == LG'(N - 1)) begin
                  ld_cnt_d = '0;
                  beat_d   = '0;
                  state_d  = S_OUT;
               end else begin
                  ld_cnt_d = ld_cnt_q + LG'(1);
               end
            end else begin
               ld_cnt_d = '0;
               state_d  = S_IDLE;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (last) begin
                  beat_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + (2*LG)'(1);
               end
            end
         end
         default: begin
            ld_cnt_d = '0;
            beat_d   = '0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // Control state with asynchronous clear so out_valid drops immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ld_cnt_q <= '0;
         beat_q   <= '0;
         elem_q   <= 1'b0;
`ifdef OUTER_PROD_COLMAJOR_EN
         col_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         beat_q   <= beat_d;
         elem_q   <= elem_d;
`ifdef OUTER_PROD_COLMAJOR_EN
         col_q    <= col_d;
`endif
      end
   end

   // Operand storage is unreset; out_data masks it whenever no job is streaming.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         a_q[ld_cnt_q] <= in_a;
         b_q[ld_cnt_q] <= in_b;
      end
   end

endmodule

// File: tb/tb_outer_prod_gen.sv
// tb_outer_prod_gen: directed scoreboard bench for outer_prod_gen (N=16, W=4).
module tb_outer_prod_gen;

   localparam int N = 16;
   localparam int W = 4;
`ifdef OUTER_PROD_COLMAJOR_EN
   localparam bit COL_EN = 1'b1;
`else
   localparam bit COL_EN = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic [1:0]     in_mode;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_ready;
   logic           out_valid;
   logic [2*W-1:0] out_data;

   int             tests = 0;
   int             fails = 0;
   int             beats_acc = 0;
   int             valid_cycles = 0;
   bit             mon_en = 1'b0;
   logic [2*W-1:0] exp_q [$];
   logic [2*W-1:0] got [256];
   logic [W-1:0]   av [N];
   logic [W-1:0]   bv [N];

   outer_prod_gen #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: compare every valid beat, pop on handshake, check zero data when idle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid === 1'b1) begin
            valid_cycles++;
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               chk("beat_data", out_data, exp_q[0]);
               if (out_ready) begin
                  if (beats_acc < 256) got[beats_acc] = out_data;
                  beats_acc++;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("idle_valid_known", out_valid, 0);
            chk("idle_data_zero", out_data, 0);
         end
      end
   end

   task automatic push_model(input logic [1:0] mode);
      bit col;
      col = COL_EN && mode[1];
      if (mode[0]) begin
         for (int k = 0; k < N; k++) exp_q.push_back(8'(av[k]) * 8'(bv[k]));
      end else begin
         for (int k = 0; k < N*N; k++)
            exp_q.push_back(col ? 8'(av[k%N]) * 8'(bv[k/N]) : 8'(av[k/N]) * 8'(bv[k%N]));
      end
   endtask

   task automatic drive_job(input logic [1:0] mode, input int nel);
      if (nel == N) push_model(mode);
      for (int i = 0; i < nel; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_mode  = (i == 0) ? mode : 2'($urandom_range(0, 3));
         in_a     = av[i];
         in_b     = bv[i];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      chk("out_valid_latency", out_valid, (nel == N) ? 1 : 0);
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (exp_q.size() > 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("job_drained", exp_q.size(), 0);
      chk("end_valid_low", out_valid, 0);
      chk("end_data_zero", out_data, 0);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         av[i] = W'($urandom);
         bv[i] = W'($urandom);
      end
   endtask

   initial begin
      int c;
      rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00;
      in_a = '0; in_b = '0; out_ready = 1'b1;
      #12;
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Outer row-major, a ascending, b descending
      for (int i = 0; i < N; i++) begin av[i] = W'(i); bv[i] = W'(15 - i); end
      beats_acc = 0;
      drive_job(2'b00, N);
      wait_done(400);
      chk("rm_beats", beats_acc, 256);
      chk("rm_beat0", got[0], 0);
      chk("rm_beat17", got[17], 14);
      chk("rm_beat255", got[255], 0);

      // Element-wise, all operands 15
      for (int i = 0; i < N; i++) begin av[i] = 4'hF; bv[i] = 4'hF; end
      beats_acc = 0;
      drive_job(2'b01, N);
      wait_done(100);
      chk("ew_beats", beats_acc, 16);
      chk("ew_beat0", got[0], 225);
      chk("ew_beat15", got[15], 225);

      // Mode 2: column-major only when the option is built in
      for (int i = 0; i < N; i++) begin av[i] = W'(i); bv[i] = 4'd1; end
      beats_acc = 0;
      drive_job(2'b10, N);
      wait_done(400);
      chk("cm_beats", beats_acc, 256);
      chk("cm_beat5", got[5], COL_EN ? 5 : 0);
      chk("cm_beat33", got[33], COL_EN ? 1 : 2);
      chk("cm_beat255", got[255], 15);

      // out_ready toggling every cycle: 256 beats over 511 valid cycles
      rand_ops();
      beats_acc = 0;
      valid_cycles = 0;
      drive_job(2'b00, N);
      c = 0;
      while (exp_q.size() > 0 && c < 1000) begin
         @(posedge clk); #1;
         out_ready = ~out_ready;
         c++;
      end
      out_ready = 1'b1;
      chk("stall_drained", exp_q.size(), 0);
      chk("stall_beats", beats_acc, 256);
      chk("stall_valid_cycles", valid_cycles, 511);
      chk("stall_end_valid", out_valid, 0);

      // Aborted load after 7 elements, then a full job
      rand_ops();
      drive_job(2'b00, 7);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_valid", out_valid, 0);
      rand_ops();
      beats_acc = 0;
      drive_job(2'b01, N);
      wait_done(100);
      chk("abort_next_beats", beats_acc, 16);

      // in_valid during OUT must be ignored
      rand_ops();
      beats_acc = 0;
      drive_job(2'b01, N);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_mode  = 2'($urandom_range(0, 3));
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_done(100);
      chk("ignore_beats", beats_acc, 16);

      // Back-to-back jobs
      rand_ops();
      drive_job(2'b11, N);
      wait_done(400);
      rand_ops();
      drive_job(2'b00, N);
      wait_done(400);

      // Asynchronous reset mid-OUT, then a clean job
      rand_ops();
      beats_acc = 0;
      drive_job(2'b00, N);
      c = 0;
      while (beats_acc < 100 && c < 500) begin
         @(posedge clk); #3;
         c++;
      end
      chk("reach_beat100", beats_acc >= 100, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", out_valid, 0);
      rand_ops();
      beats_acc = 0;
      drive_job(2'b00, N);
      wait_done(400);
      chk("post_rst_beats", beats_acc, 256);
      chk("post_rst_beat0", got[0], 8'(av[0]) * 8'(bv[0]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
